// File: rtl/jump_redirect_unit.sv
// Decode-to-execute pipeline register that resolves JAL/JALR, pulses a redirect to fetch and
// squashes a fixed number of wrong-path instructions behind it.
module jump_redirect_unit #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned XLEN         = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [21:0]     in_ctrl,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [21:0]     out_ctrl,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_link,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            misalign_exc,
   output logic [2:0]      squash_cnt
);

   typedef enum logic [1:0] {StRun, StRedirect, StFlush} state_e;

   localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [21:0]       out_ctrl_q, out_ctrl_d;
   logic [XLEN-1:0]   out_pc_q, out_pc_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic [XLEN-1:0]   out_link_q, out_link_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic [2:0]        squash_q, squash_d;

   logic accept;
   logic is_jump;
   logic in_redirect;
   logic fire;
   logic misalign;

   assign is_jump     = in_ctrl[19];
   assign in_redirect = (state_q == StRedirect);
   assign in_ready    = !in_redirect && !(out_valid_q && !out_ready);
   assign accept      = in_valid && in_ready;
   assign fire        = in_redirect && !target_q[1];
   assign misalign    = in_redirect && target_q[1];

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_ctrl_d  = out_ctrl_q;
      out_pc_d    = out_pc_q;
      out_rd_d    = out_rd_q;
      out_link_d  = out_link_q;
      target_d    = target_q;
      squash_d    = squash_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // Wrong-path instructions in FLUSH are consumed without ever reaching the output.
      if (accept && (state_q != StFlush)) begin
         out_valid_d = 1'b1;
         out_ctrl_d  = in_ctrl;
         out_pc_d    = in_pc;
         out_rd_d    = in_rd;
         out_link_d  = is_jump ? in_pc + XLEN'(4) : '0;
      end

      if (accept && is_jump && (state_q == StRun)) begin
         if (in_ctrl[8:7] == 2'b01) begin
            target_d = (in_rs1 + in_imm) & ~XLEN'(1);
         end else begin
            target_d = in_pc + in_imm;
         end
      end

      unique case (state_q)
         StRun: begin
            if (accept && is_jump) begin
               state_d = StRedirect;
            end
         end
         StRedirect: begin
            if (target_q[1]) begin
               out_ctrl_d[21] = 1'b0;
               state_d        = StRun;
            end else begin
               squash_d = FlushInit;
               state_d  = StFlush;
            end
         end
         StFlush: begin
            if (accept) begin
               squash_d = squash_q - 3'd1;
               if (squash_q == 3'd1) begin
                  state_d = StRun;
               end
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StRun;
         out_valid_q <= 1'b0;
         out_ctrl_q  <= '0;
         out_pc_q    <= '0;
         out_rd_q    <= '0;
         out_link_q  <= '0;
         target_q    <= '0;
         squash_q    <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_ctrl_q  <= out_ctrl_d;
         out_pc_q    <= out_pc_d;
         out_rd_q    <= out_rd_d;
         out_link_q  <= out_link_d;
         target_q    <= target_d;
         squash_q    <= squash_d;
      end
   end

   assign out_valid      = out_valid_q;
   // A misaligned jump may still be visible during REDIRECT; suppress its link write at once.
   assign out_ctrl       = {out_ctrl_q[21] & ~misalign, out_ctrl_q[20:0]};
   assign out_pc         = out_pc_q;
   assign out_rd         = out_rd_q;
   assign out_link       = out_link_q;
   assign redirect_valid = fire;
   assign redirect_pc    = fire ? target_q : '0;
   assign misalign_exc   = misalign;
   assign squash_cnt     = fire ? FlushInit : squash_q;

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Directed bench for jump_redirect_unit: pass-through, JAL/JALR redirect and flush, misalignment,
// output stall during a redirect, and reset in the middle of a flush.
module tb_jump_redirect_unit;

   localparam int unsigned XLEN = 32;
   localparam logic [21:0] CtrlAlu  = 22'h200010;
   localparam logic [21:0] CtrlJal  = 22'h3D8C18;
   localparam logic [21:0] CtrlJalr = 22'h280080;

   logic            clk = 1'b0;
   logic            rstn;
   logic            in_valid;
   logic            in_ready;
   logic [21:0]     in_ctrl;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_imm;
   logic [4:0]      in_rd;
   logic            out_valid;
   logic            out_ready;
   logic [21:0]     out_ctrl;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_link;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            misalign_exc;
   logic [2:0]      squash_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   jump_redirect_unit #(
      .FLUSH_CYCLES(2),
      .XLEN        (XLEN)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_ctrl       (in_ctrl),
      .in_pc         (in_pc),
      .in_rs1        (in_rs1),
      .in_imm        (in_imm),
      .in_rd         (in_rd),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_ctrl      (out_ctrl),
      .out_pc        (out_pc),
      .out_rd        (out_rd),
      .out_link      (out_link),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .misalign_exc  (misalign_exc),
      .squash_cnt    (squash_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [21:0] c, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [4:0] rd);
      in_valid = v;
      in_ctrl  = c;
      in_pc    = pc;
      in_rs1   = rs1;
      in_imm   = imm;
      in_rd    = rd;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
      check({tag, ".out_ctrl"}, 64'(out_ctrl), 64'd0);
      check({tag, ".out_pc"}, 64'(out_pc), 64'd0);
      check({tag, ".out_link"}, 64'(out_link), 64'd0);
      check({tag, ".redirect"}, 64'(redirect_valid), 64'd0);
      check({tag, ".misalign"}, 64'(misalign_exc), 64'd0);
      check({tag, ".squash"}, 64'(squash_cnt), 64'd0);
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      rstn      = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, '0, '0, '0, '0, '0);
      #1;
      check_idle_outputs("reset");
      #12 rstn = 1'b1;
      #3;

      // ALU stream passes straight through
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, CtrlAlu, 32'(i * 4), 32'h0, 32'h0, 5'd3);
         step();
         check("alu.valid", 64'(out_valid), 64'd1);
         check("alu.pc", 64'(out_pc), 64'(i * 4));
         check("alu.link", 64'(out_link), 64'd0);
         check("alu.redirect", 64'(redirect_valid), 64'd0);
      end
      drive(1'b0, CtrlAlu, 32'h0, 32'h0, 32'h0, 5'd0);
      step();
      check("alu.drain", 64'(out_valid), 64'd0);

      // JAL: redirect to 0x140, squash two, third passes
      drive(1'b1, CtrlJal, 32'h100, 32'h0, 32'h40, 5'd1);
      step();
      check("jal.redirect", 64'(redirect_valid), 64'd1);
      check("jal.redirect_pc", 64'(redirect_pc), 64'h140);
      check("jal.link", 64'(out_link), 64'h104);
      check("jal.out_pc", 64'(out_pc), 64'h100);
      check("jal.out_rd", 64'(out_rd), 64'd1);
      check("jal.out_ctrl", 64'(out_ctrl), 64'(CtrlJal));
      check("jal.in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, CtrlAlu, 32'h104, 32'h0, 32'h0, 5'd2);
      step();
      check("jal.redirect_end", 64'(redirect_valid), 64'd0);
      check("jal.sq2", 64'(squash_cnt), 64'd2);
      check("jal.drained", 64'(out_valid), 64'd0);
      step();
      check("jal.sq1", 64'(squash_cnt), 64'd1);
      check("jal.sq1_valid", 64'(out_valid), 64'd0);
      drive(1'b1, CtrlJal, 32'h108, 32'h0, 32'h40, 5'd1);
      step();
      check("jal.sq0", 64'(squash_cnt), 64'd0);
      check("jal.sq0_valid", 64'(out_valid), 64'd0);
      check("jal.squashed_jump", 64'(redirect_valid), 64'd0);
      drive(1'b1, CtrlAlu, 32'h140, 32'h0, 32'h0, 5'd4);
      step();
      check("jal.pass_valid", 64'(out_valid), 64'd1);
      check("jal.pass_pc", 64'(out_pc), 64'h140);
      check("jal.pass_redirect", 64'(redirect_valid), 64'd0);

      // JALR with odd target clears bit 0; squash count holds without accepts
      drive(1'b1, CtrlJalr, 32'h200, 32'h2001, 32'h10, 5'd5);
      step();
      check("jalr.redirect", 64'(redirect_valid), 64'd1);
      check("jalr.redirect_pc", 64'(redirect_pc), 64'h2010);
      check("jalr.link", 64'(out_link), 64'h204);
      drive(1'b0, CtrlAlu, 32'h0, 32'h0, 32'h0, 5'd0);
      step();
      step();
      check("jalr.sq_hold", 64'(squash_cnt), 64'd2);
      drive(1'b1, CtrlAlu, 32'h204, 32'h0, 32'h0, 5'd0);
      step();
      step();
      check("jalr.sq_done", 64'(squash_cnt), 64'd0);
      check("jalr.sq_valid", 64'(out_valid), 64'd0);
      drive(1'b0, CtrlAlu, 32'h0, 32'h0, 32'h0, 5'd0);
      step();

      // JALR to 0x2002: misaligned, no redirect, link write dropped
      drive(1'b1, CtrlJalr, 32'h300, 32'h2002, 32'h0, 5'd6);
      step();
      check("mis.exc", 64'(misalign_exc), 64'd1);
      check("mis.redirect", 64'(redirect_valid), 64'd0);
      check("mis.we_reg", 64'(out_ctrl[21]), 64'd0);
      check("mis.link", 64'(out_link), 64'h304);
      drive(1'b0, CtrlAlu, 32'h0, 32'h0, 32'h0, 5'd0);
      step();
      check("mis.exc_end", 64'(misalign_exc), 64'd0);
      check("mis.squash", 64'(squash_cnt), 64'd0);
      drive(1'b1, CtrlAlu, 32'h304, 32'h0, 32'h0, 5'd7);
      step();
      check("mis.next_valid", 64'(out_valid), 64'd1);
      check("mis.next_pc", 64'(out_pc), 64'h304);
      drive(1'b0, CtrlAlu, 32'h0, 32'h0, 32'h0, 5'd0);
      step();

      // JAL with execute stalled for three cycles
      out_ready = 1'b0;
      drive(1'b1, CtrlJal, 32'h400, 32'h0, 32'h20, 5'd1);
      step();
      check("stall.redirect", 64'(redirect_valid), 64'd1);
      check("stall.redirect_pc", 64'(redirect_pc), 64'h420);
      check("stall.in_ready0", 64'(in_ready), 64'd0);
      drive(1'b1, CtrlAlu, 32'h404, 32'h0, 32'h0, 5'd2);
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall.in_ready", 64'(in_ready), 64'd0);
         check("stall.hold_valid", 64'(out_valid), 64'd1);
         check("stall.hold_pc", 64'(out_pc), 64'h400);
         check("stall.hold_link", 64'(out_link), 64'h404);
         check("stall.sq", 64'(squash_cnt), 64'd2);
         check("stall.redirect_once", 64'(redirect_valid), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("stall.release_ready", 64'(in_ready), 64'd1);
      step();
      check("stall.sq1", 64'(squash_cnt), 64'd1);
      check("stall.released", 64'(out_valid), 64'd0);

      // Reset mid-flush
      drive(1'b0, CtrlAlu, 32'h0, 32'h0, 32'h0, 5'd0);
      #2 rstn = 1'b0;
      #1;
      check_idle_outputs("midrst");
      #10 rstn = 1'b1;
      drive(1'b1, CtrlAlu, 32'h500, 32'h0, 32'h0, 5'd8);
      step();
      check("midrst.pass_valid", 64'(out_valid), 64'd1);
      check("midrst.pass_pc", 64'(out_pc), 64'h500);
      check("midrst.squash", 64'(squash_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
